k2_program_loader: RTL and testbench
====================================

# k2_program_loader

Writable program memory and loader for the K2 processor, the writer-side counterpart of the fixed program ROMs. A byte-stream ready/valid interface fills a 2^ADDR_W x DATA_W instruction store while the processor is held in reset. The block then releases the processor and serves `instruction_data` for its `ProgramAddress` fetches, so a program can be swapped without resynthesis.

## Interface
- `ADDR_W`, 4, program address width; depth = 2^ADDR_W.
- `DATA_W`, 8, instruction width.

- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_start`  in  1  single-cycle pulse that begins a new load.
- `load_valid`  in  1  `load_data` is valid.
- `load_data`  in  DATA_W  next program byte.
- `load_last`  in  1  qualifies the final program byte (early termination).
- `load_ready`  out  1  loader accepts a byte this cycle.
- `ProgramAddress`  in  ADDR_W  fetch address from the processor.
- `instruction_data`  out  DATA_W  instruction at `ProgramAddress`.
- `cpu_rst_n`  out  1  active-low reset to the processor; low except in RUN.
- `load_done`  out  1  high in RUN.
- `load_count`  out  ADDR_W+1  bytes stored by the most recent load.
- `load_error`  out  1  checksum failure (see Configuration).

## Operation
- States: IDLE, LOAD, CHECK (macro only), RUN, ERROR.
- IDLE: `cpu_rst_n`=0, `load_ready`=0. `load_start` goes to LOAD.
- LOAD: `load_ready`=1. Each `load_valid & load_ready` writes `mem[ptr]` and increments `ptr` and `load_count`.
  - Entry clears `ptr` and `load_count` to 0. Memory is not cleared, so unwritten locations keep earlier contents.
  - Leaves LOAD after an accepted byte with `load_last`=1, or after the byte written at `ptr`=2^ADDR_W-1 (auto-terminate; `load_last` ignored).
  - Next state is RUN, or CHECK with the macro.
- RUN: `cpu_rst_n`=1, `load_done`=1, `load_ready`=0.
- ERROR: `cpu_rst_n`=0, `load_error`=1.
- `load_start` in any state, including LOAD, RUN and ERROR, restarts to LOAD. A byte presented in the same cycle is dropped.
- Read path: combinational `instruction_data = mem[ProgramAddress]` in RUN. It is 0 in all other states.

## Timing
- Reset values:
  - State IDLE.
  - Memory all 0x00; `ptr` 0; `load_count` 0.
  - `load_ready` 0, `cpu_rst_n` 0, `load_done` 0, `load_error` 0.
  - `instruction_data` 0.
- Reset mid-load discards the partial load and returns to these values.
- `load_ready` rises the cycle after `load_start` is sampled. Throughput is one byte per cycle.
- A written byte is visible on the read path from the next cycle. The read path is only exposed in RUN.
- Last byte accepted at edge N: state is RUN (or CHECK) after N. `cpu_rst_n` and `load_done` are high from edge N, with no gap cycle.
- Outputs are registered state decodes, except `instruction_data`, which is combinational from `ProgramAddress`.
- `load_count` ranges from 0 to 2^ADDR_W. It equals 16 after a full default-size load.

## Configuration
- Macro `K2_LOADER_CHECKSUM_EN`.
- Defined:
  - LOAD accumulates an 8-bit modulo-256 sum of the accepted program bytes, truncated to DATA_W.
  - After the terminating byte, the block enters CHECK with `load_ready`=1. The next accepted byte is the checksum and is not written to memory.
  - Match goes to RUN. Mismatch goes to ERROR.
  - The sum is cleared on LOAD entry.
- Undefined: CHECK and ERROR are unreachable, `load_error` is tied 0, and there is no checksum byte.

## Test plan
- Reset then idle: `cpu_rst_n`=0, `load_ready`=0 and `instruction_data`=0x00 for any `ProgramAddress`. No state change without `load_start`.
- Load 16 bytes 0x10..0x1F back-to-back with `load_last`=0: auto-terminate, `load_count`=16, `cpu_rst_n`=1 from the last-accept edge. `ProgramAddress`=5 gives 0x15.
- Load 3 bytes (0xA1, 0xB2, 0xC3) with `load_last` on the third: `load_count`=3. Address 2 gives 0xC3 and address 3 gives its prior value (0x00 after reset). Toggle `load_valid` with gaps; only handshaked bytes are stored.
- `load_start` while in RUN: `cpu_rst_n` falls the next cycle. A new 2-byte load of 0x55, 0x66 makes address 0 read 0x55, while address 7 keeps its old value.
- `load_start` coinciding with a valid byte mid-LOAD: the byte is dropped and `load_count` restarts at 0. Assert `rst` mid-load: memory reads 0x00 and state is IDLE.
- With `K2_LOADER_CHECKSUM_EN`:
  - Bytes 0x01, 0x02 (`load_last`), then checksum 0x03: RUN.
  - Repeat with checksum 0x04: ERROR, `load_error`=1, `cpu_rst_n`=0. A following `load_start` clears `load_error` and returns to LOAD.

Source files
------------

// File: rtl/k2_program_loader.sv
// Writable K2 program store: a byte stream fills memory while the CPU is held in reset, then the CPU runs from it.
// Optional trailing checksum byte is enabled by defining K2_LOADER_CHECKSUM_EN.
module k2_program_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] ProgramAddress,
    output logic [DATA_W-1:0] instruction_data,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              load_error
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
`ifdef K2_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;
`endif

    logic [2:0]        state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic              accept;
    logic              write_en;
    logic              last_byte;

    // A restart pulse wins over any byte offered in the same cycle.
    assign accept    = load_valid & load_ready & ~load_start;
    assign write_en  = accept && (state_reg == ST_LOAD);
    assign last_byte = load_last || (ptr_reg == {ADDR_W{1'b1}});

`ifdef K2_LOADER_CHECKSUM_EN
    logic [7:0] sum_reg;

    always_ff @(posedge clk) begin
        if (rst || load_start) begin
            sum_reg <= '0;
        end else if (write_en) begin
            sum_reg <= sum_reg + 8'(load_data);
        end
    end

    assign load_ready = (state_reg == ST_LOAD) || (state_reg == ST_CHECK);
    assign load_error = (state_reg == ST_ERROR);
`else
    assign load_ready = (state_reg == ST_LOAD);
    assign load_error = 1'b0;
`endif

    assign cpu_rst_n  = (state_reg == ST_RUN);
    assign load_done  = (state_reg == ST_RUN);
    assign load_count = count_reg;

    always_comb begin
        state_next = state_reg;
        if (load_start) begin
            state_next = ST_LOAD;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_IDLE;
                ST_LOAD: begin
                    if (accept && last_byte) begin
`ifdef K2_LOADER_CHECKSUM_EN
                        state_next = ST_CHECK;
`else
                        state_next = ST_RUN;
`endif
                    end
                end
`ifdef K2_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        state_next = (load_data == DATA_W'(sum_reg)) ? ST_RUN : ST_ERROR;
                    end
                end
                ST_ERROR: state_next = ST_ERROR;
`endif
                ST_RUN:  state_next = ST_RUN;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (load_start) begin
                ptr_reg   <= '0;
                count_reg <= '0;
            end else if (write_en) begin
                ptr_reg   <= ptr_reg + ADDR_W'(1);
                count_reg <= count_reg + (ADDR_W+1)'(1);
            end
        end
    end

    // Small store kept in registers so reset can clear every word.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (write_en && (ptr_reg == ADDR_W'(gi))) begin
                    mem_reg[gi] <= load_data;
                end
            end
        end
    endgenerate

    assign instruction_data = (state_reg == ST_RUN) ? mem_reg[ProgramAddress] : '0;

endmodule

// File: tb/tb_k2_program_loader.sv
// Directed self-checking bench for k2_program_loader; build with K2_LOADER_CHECKSUM_EN to also cover the checksum path.
module tb_k2_program_loader;

`ifdef K2_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_last = 1'b0;
    logic       load_ready;
    logic [3:0] ProgramAddress = 4'h0;
    logic [7:0] instruction_data;
    logic       cpu_rst_n;
    logic       load_done;
    logic [4:0] load_count;
    logic       load_error;

    int checks = 0;
    int fails  = 0;

    k2_program_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .ProgramAddress(ProgramAddress), .instruction_data(instruction_data),
        .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_count(load_count),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Supplies the trailing checksum byte only when the checksum build is active.
    task automatic finish_check(input logic [7:0] sum);
        if (CK) send_byte(sum, 1'b0);
    endtask

    task automatic read_at(input logic [3:0] a);
        ProgramAddress = a;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (load_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", load_ready); end
        checks++; if (cpu_rst_n !== 1'b0) begin fails++; $display("FAIL reset_cpu_rst_n: got %b want 0", cpu_rst_n); end
        checks++; if (load_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", load_done); end
        checks++; if (load_error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", load_error); end
        checks++; if (load_count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", load_count); end
        for (int a = 0; a < 16; a += 5) begin
            read_at(4'(a));
            checks++; if (instruction_data !== 8'h00) begin fails++; $display("FAIL reset_read[%0d]: got %h want 00", a, instruction_data); end
        end
        tick(); tick(); tick();
        checks++; if (cpu_rst_n !== 1'b0 || load_ready !== 1'b0) begin fails++; $display("FAIL idle_hold: got rst_n=%b ready=%b want 0 0", cpu_rst_n, load_ready); end
        $display("reset: idle checked");
    endtask

    task automatic test_short_load();
        pulse_start();
        checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL short_ready: got %b want 1", load_ready); end
        send_byte(8'hA1, 1'b0);
        load_data = 8'hEE;
        tick();
        send_byte(8'hB2, 1'b0);
        tick();
        send_byte(8'hC3, 1'b1);
        checks++; if (cpu_rst_n !== !CK) begin fails++; $display("FAIL short_rst_n_edge: got %b want %b", cpu_rst_n, !CK); end
        finish_check(8'h16);
        checks++; if (load_count !== 5'd3) begin fails++; $display("FAIL short_count: got %0d want 3", load_count); end
        checks++; if (load_done !== 1'b1) begin fails++; $display("FAIL short_done: got %b want 1", load_done); end
        read_at(4'd0);
        checks++; if (instruction_data !== 8'hA1) begin fails++; $display("FAIL short_addr0: got %h want a1", instruction_data); end
        read_at(4'd2);
        checks++; if (instruction_data !== 8'hC3) begin fails++; $display("FAIL short_addr2: got %h want c3", instruction_data); end
        read_at(4'd3);
        checks++; if (instruction_data !== 8'h00) begin fails++; $display("FAIL short_addr3: got %h want 00", instruction_data); end
        $display("load: 3 bytes a1 b2 c3 with gaps");
    endtask

    task automatic test_full_load();
        pulse_start();
        checks++; if (cpu_rst_n !== 1'b0) begin fails++; $display("FAIL full_rst_n_low: got %b want 0", cpu_rst_n); end
        for (int i = 0; i < 15; i++) begin
            send_byte(8'h10 + 8'(i), 1'b0);
        end
        checks++; if (cpu_rst_n !== 1'b0 || load_ready !== 1'b1) begin fails++; $display("FAIL full_pre_last: got rst_n=%b ready=%b want 0 1", cpu_rst_n, load_ready); end
        checks++; if (load_count !== 5'd15) begin fails++; $display("FAIL full_count15: got %0d want 15", load_count); end
        send_byte(8'h1F, 1'b0);
        checks++; if (cpu_rst_n !== !CK) begin fails++; $display("FAIL full_rst_n_edge: got %b want %b", cpu_rst_n, !CK); end
        finish_check(8'h78);
        checks++; if (load_count !== 5'd16) begin fails++; $display("FAIL full_count: got %0d want 16", load_count); end
        checks++; if (cpu_rst_n !== 1'b1 || load_ready !== 1'b0) begin fails++; $display("FAIL full_run: got rst_n=%b ready=%b want 1 0", cpu_rst_n, load_ready); end
        read_at(4'd5);
        checks++; if (instruction_data !== 8'h15) begin fails++; $display("FAIL full_addr5: got %h want 15", instruction_data); end
        read_at(4'd15);
        checks++; if (instruction_data !== 8'h1F) begin fails++; $display("FAIL full_addr15: got %h want 1f", instruction_data); end
        $display("load: 16 bytes 10..1f auto-terminated");
    endtask

    task automatic test_restart_in_run();
        pulse_start();
        checks++; if (cpu_rst_n !== 1'b0 || load_done !== 1'b0) begin fails++; $display("FAIL rerun_rst_n: got rst_n=%b done=%b want 0 0", cpu_rst_n, load_done); end
        checks++; if (load_count !== 5'd0 || load_ready !== 1'b1) begin fails++; $display("FAIL rerun_entry: got count=%0d ready=%b want 0 1", load_count, load_ready); end
        read_at(4'd5);
        checks++; if (instruction_data !== 8'h00) begin fails++; $display("FAIL rerun_read_hidden: got %h want 00", instruction_data); end
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b1);
        finish_check(8'hBB);
        checks++; if (load_count !== 5'd2) begin fails++; $display("FAIL rerun_count: got %0d want 2", load_count); end
        read_at(4'd0);
        checks++; if (instruction_data !== 8'h55) begin fails++; $display("FAIL rerun_addr0: got %h want 55", instruction_data); end
        read_at(4'd7);
        checks++; if (instruction_data !== 8'h17) begin fails++; $display("FAIL rerun_addr7: got %h want 17", instruction_data); end
        $display("load: restart from run, 55 66");
    endtask

    task automatic test_restart_mid_load();
        pulse_start();
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h99;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        checks++; if (load_count !== 5'd0 || load_ready !== 1'b1) begin fails++; $display("FAIL midload_restart: got count=%0d ready=%b want 0 1", load_count, load_ready); end
        send_byte(8'hAB, 1'b1);
        finish_check(8'hAB);
        checks++; if (load_count !== 5'd1) begin fails++; $display("FAIL midload_count: got %0d want 1", load_count); end
        read_at(4'd0);
        checks++; if (instruction_data !== 8'hAB) begin fails++; $display("FAIL midload_addr0: got %h want ab", instruction_data); end
        read_at(4'd1);
        checks++; if (instruction_data !== 8'h88) begin fails++; $display("FAIL midload_addr1: got %h want 88", instruction_data); end
        read_at(4'd2);
        checks++; if (instruction_data !== 8'h12) begin fails++; $display("FAIL midload_addr2: got %h want 12", instruction_data); end
        $display("load: restart mid-load drops byte 99");
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (load_ready !== 1'b0 || cpu_rst_n !== 1'b0) begin fails++; $display("FAIL rstmid_state: got ready=%b rst_n=%b want 0 0", load_ready, cpu_rst_n); end
        checks++; if (load_count !== 5'd0) begin fails++; $display("FAIL rstmid_count: got %0d want 0", load_count); end
        pulse_start();
        send_byte(8'h42, 1'b1);
        finish_check(8'h42);
        read_at(4'd0);
        checks++; if (instruction_data !== 8'h42) begin fails++; $display("FAIL rstmid_addr0: got %h want 42", instruction_data); end
        read_at(4'd1);
        checks++; if (instruction_data !== 8'h00) begin fails++; $display("FAIL rstmid_addr1: got %h want 00", instruction_data); end
        read_at(4'd15);
        checks++; if (instruction_data !== 8'h00) begin fails++; $display("FAIL rstmid_addr15: got %h want 00", instruction_data); end
        $display("load: reset mid-load, then 42");
    endtask

`ifdef K2_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        checks++; if (load_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin fails++; $display("FAIL ck_check_state: got ready=%b rst_n=%b want 1 0", load_ready, cpu_rst_n); end
        send_byte(8'h03, 1'b0);
        checks++; if (cpu_rst_n !== 1'b1 || load_error !== 1'b0) begin fails++; $display("FAIL ck_match: got rst_n=%b err=%b want 1 0", cpu_rst_n, load_error); end
        checks++; if (load_count !== 5'd2) begin fails++; $display("FAIL ck_count: got %0d want 2", load_count); end
        read_at(4'd2);
        checks++; if (instruction_data !== 8'h00) begin fails++; $display("FAIL ck_not_stored: got %h want 00", instruction_data); end
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        send_byte(8'h04, 1'b0);
        checks++; if (load_error !== 1'b1 || cpu_rst_n !== 1'b0 || load_done !== 1'b0) begin fails++; $display("FAIL ck_mismatch: got err=%b rst_n=%b done=%b want 1 0 0", load_error, cpu_rst_n, load_done); end
        read_at(4'd0);
        checks++; if (instruction_data !== 8'h00) begin fails++; $display("FAIL ck_err_read: got %h want 00", instruction_data); end
        pulse_start();
        checks++; if (load_error !== 1'b0 || load_ready !== 1'b1) begin fails++; $display("FAIL ck_recover: got err=%b ready=%b want 0 1", load_error, load_ready); end
        $display("load: checksum match and mismatch");
    endtask
`endif

    initial begin
        test_reset();
        test_short_load();
        test_full_load();
        test_restart_in_run();
        test_restart_mid_load();
        test_reset_mid_load();
`ifdef K2_LOADER_CHECKSUM_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
